// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions: mesh geometry, flit types and head-flit field layout.
// Used by both the transmitting and the receiving endpoint.
package noc_flit_pkg;

   typedef struct packed {
      int unsigned size_x;
      int unsigned size_y;
   } noc_config_t;

   localparam noc_config_t NOC_DEFAULT_CONFIG = '{size_x: 4, size_y: 4};

   typedef enum logic [1:0] {
      FT_HEAD      = 2'd0,
      FT_BODY      = 2'd1,
      FT_TAIL      = 2'd2,
      FT_HEAD_TAIL = 2'd3
   } flit_type_e;

   // Head fields are packed LSB-first: four CW-bit coordinates, then the length.
   typedef enum int unsigned {
      HF_DEST_X = 0,
      HF_DEST_Y = 1,
      HF_SRC_X  = 2,
      HF_SRC_Y  = 3,
      HF_LENGTH = 4
   } head_field_e;

   function automatic int unsigned head_lsb(head_field_e f, int unsigned cw);
      return int'(f) * cw;
   endfunction

endpackage

// File: rtl/noc_flit_out_reg.sv
// Single flit output register with valid/ready hold: a loaded flit stays put
// until it is accepted, and a new flit may load on the accepting edge.
module noc_flit_out_reg
   import noc_flit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  flit_type_e            load_type,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  flit_ready,
   output logic                  flit_valid,
   output flit_type_e            flit_type,
   output logic [DATA_WIDTH-1:0] flit_data,
   output logic                  can_load
);

   assign can_load = !flit_valid || flit_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         flit_valid <= 1'b0;
         flit_type  <= FT_HEAD;
         flit_data  <= '0;
      end else if (load) begin
         flit_valid <= 1'b1;
         flit_type  <= load_type;
         flit_data  <= load_data;
      end else if (flit_ready) begin
         flit_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/noc_packet_transmitter.sv
// NoC endpoint transmitter: turns a packet header plus payload words into a
// HEAD/BODY/TAIL (or single HEAD_TAIL) flit stream toward the local router port.
module noc_packet_transmitter
   import noc_flit_pkg::*;
#(
   parameter noc_config_t CONFIG      = NOC_DEFAULT_CONFIG,
   parameter int          X           = 0,
   parameter int          Y           = 0,
   parameter int          DATA_WIDTH  = 32,
   parameter int          MAX_PAYLOAD = 16,
   localparam int         SIZE_X      = CONFIG.size_x,
   localparam int         SIZE_Y      = CONFIG.size_y,
   localparam int         SIZE_MAX    = (SIZE_X > SIZE_Y) ? SIZE_X : SIZE_Y,
   localparam int         CW          = (SIZE_MAX > 1) ? $clog2(SIZE_MAX) : 1,
   localparam int         LW          = $clog2(MAX_PAYLOAD + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pkt_valid,
   output logic                  pkt_ready,
   input  logic [CW-1:0]         pkt_dest_x,
   input  logic [CW-1:0]         pkt_dest_y,
   input  logic [LW-1:0]         pkt_length,
   input  logic                  payload_valid,
   output logic                  payload_ready,
   input  logic [DATA_WIDTH-1:0] payload_data,
   output logic                  flit_valid,
   input  logic                  flit_ready,
   output logic [1:0]            flit_type,
   output logic [DATA_WIDTH-1:0] flit_data,
   output logic                  busy,
   output logic [15:0]           tx_pkt_count
);

   localparam int OFF_DX  = head_lsb(HF_DEST_X, CW);
   localparam int OFF_DY  = head_lsb(HF_DEST_Y, CW);
   localparam int OFF_SX  = head_lsb(HF_SRC_X, CW);
   localparam int OFF_SY  = head_lsb(HF_SRC_Y, CW);
   localparam int OFF_LEN = head_lsb(HF_LENGTH, CW);

   typedef enum logic {ST_IDLE, ST_PAYLOAD} state_e;

   state_e                state_q, state_d;
   logic [LW-1:0]         rem_q, rem_d;
   logic                  can_load, load;
   flit_type_e            load_type, type_q;
   logic [DATA_WIDTH-1:0] load_data, head_word;
   logic                  pkt_fire, pay_fire;

   assign pkt_ready     = (state_q == ST_IDLE) && can_load;
   assign payload_ready = (state_q == ST_PAYLOAD) && can_load;
   assign pkt_fire      = pkt_valid && pkt_ready;
   assign pay_fire      = payload_valid && payload_ready;
   assign busy          = (state_q != ST_IDLE) || flit_valid;
   assign flit_type     = type_q;

   always_comb begin
      head_word                    = '0;
      head_word[OFF_DX +: CW]      = pkt_dest_x;
      head_word[OFF_DY +: CW]      = pkt_dest_y;
      head_word[OFF_SX +: CW]      = CW'(X);
      head_word[OFF_SY +: CW]      = CW'(Y);
      head_word[OFF_LEN +: LW]     = pkt_length;
   end

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      load      = 1'b0;
      load_type = FT_HEAD;
      load_data = head_word;
      case (state_q)
         ST_IDLE: begin
            if (pkt_fire) begin
               load = 1'b1;
               if (pkt_length == '0) begin
                  load_type = FT_HEAD_TAIL;
               end else begin
                  state_d = ST_PAYLOAD;
                  rem_d   = pkt_length;
               end
            end
         end
         ST_PAYLOAD: begin
            if (pay_fire) begin
               load      = 1'b1;
               load_data = payload_data;
               rem_d     = rem_q - LW'(1);
               if (rem_q == LW'(1)) begin
                  load_type = FT_TAIL;
                  state_d   = ST_IDLE;
               end else begin
                  load_type = FT_BODY;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   // A packet counts as sent only once its last flit leaves the register.
   always_ff @(posedge clk) begin
      if (rst)
         tx_pkt_count <= '0;
      else if (flit_valid && flit_ready && (type_q == FT_TAIL || type_q == FT_HEAD_TAIL))
         tx_pkt_count <= tx_pkt_count + 16'd1;
   end

   noc_flit_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_type  (load_type),
      .load_data  (load_data),
      .flit_ready (flit_ready),
      .flit_valid (flit_valid),
      .flit_type  (type_q),
      .flit_data  (flit_data),
      .can_load   (can_load)
   );

endmodule
